// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds one byte at a time from NUM_REQ requesters
// to a single UART transmitter, with launch/done handshake, inter-frame gap and abort timeout.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned GAP_CYC     = 1
) (
    input  logic                       i_tx_clk,
    input  logic                       i_tx_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*8-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_start_bit,
    output logic [7:0]                 o_data_out,
    input  logic                       i_tx_busy,
    input  logic                       i_tx_data_done,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_active,
    output logic                       o_timeout_err,
    input  logic                       i_err_clr
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned SW = GW + 1;
    localparam int unsigned TW = 10;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    localparam state_t AFTER_FRAME = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   win;
    logic [GW-1:0]   cand;
    logic [SW-1:0]   sum;
    logic            found;
    logic [TW-1:0]   tmo_cnt;
    logic [CW-1:0]   gap_cnt;
    logic            done_q;
    logic            done_edge;
    logic            tmo_max;
    logic            gap_last;
    logic            grant_en;
    logic            finish;
    logic            tmo_hit;

    assign done_edge = i_tx_data_done & ~done_q;
    assign tmo_max   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign gap_last  = (gap_cnt == CW'(GAP_CYC - 1));

    // Round-robin search starting just after the previous owner, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, last_grant} + SW'(i + 1);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            cand = sum[GW-1:0];
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge i_tx_clk or negedge i_tx_rst) begin
        if (!i_tx_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the accept pulse; a done edge wins over a coincident timeout.
    always_comb begin
        state_nxt   = state;
        grant_en    = 1'b0;
        finish      = 1'b0;
        tmo_hit     = 1'b0;
        o_req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_en  = 1'b1;
                    state_nxt = ST_LAUNCH;
                    if (i_tx_rst) begin
                        o_req_ready[win] = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                if (tmo_max) begin
                    tmo_hit   = 1'b1;
                    finish    = 1'b1;
                    state_nxt = AFTER_FRAME;
                end else if (i_tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_edge) begin
                    finish    = 1'b1;
                    state_nxt = AFTER_FRAME;
                end else if (tmo_max) begin
                    tmo_hit   = 1'b1;
                    finish    = 1'b1;
                    state_nxt = AFTER_FRAME;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: captured byte/owner, counters, done history and sticky error.
    always_ff @(posedge i_tx_clk or negedge i_tx_rst) begin
        if (!i_tx_rst) begin
            last_grant    <= GW'(NUM_REQ - 1);
            o_grant_id    <= '0;
            o_data_out    <= 8'h00;
            o_start_bit   <= 1'b0;
            o_active      <= 1'b0;
            o_timeout_err <= 1'b0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q      <= i_tx_data_done;
            o_start_bit <= (state_nxt == ST_LAUNCH);
            o_active    <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_WAIT_DONE);
            if (grant_en) begin
                o_data_out <= i_req_data[{win, 3'b000} +: 8];
                o_grant_id <= win;
                tmo_cnt    <= '0;
            end else if ((state == ST_LAUNCH) || (state == ST_WAIT_DONE)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (finish) begin
                last_grant <= o_grant_id;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + CW'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (tmo_hit) begin
                o_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                o_timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 64, sets the maximum cycles from launch to done before abort; legal range 16..1023.
REQ-003 Parameter GAP_CYC, default 1, sets the idle cycles inserted between frames; legal range 0..15.
REQ-004 The clock and reset SHALL be: reset i_tx_rst, asynchronous, active-low; clock i_tx_clk.
REQ-005 The ports after clock and reset SHALL be:
- i_req_valid  in  NUM_REQ  per-requester byte-pending flag.
- i_req_data  in  NUM_REQ*8  packed bytes; requester k uses bits [8k+7:8k].
- o_req_ready  out  NUM_REQ  one-hot accept pulse.
- o_start_bit  out  1  start request to the transmitter.
- o_data_out  out  8  byte to the transmitter.
- i_tx_busy  in  1  transmitter busy.
- i_tx_data_done  in  1  transmitter stop-bit done flag.
- o_grant_id  out  clog2(NUM_REQ)  index of the current owner.
- o_active  out  1  a frame is in flight.
- o_timeout_err  out  1  sticky abort flag.
- i_err_clr  in  1  clears o_timeout_err.

Function
REQ-006 The FSM SHALL have the states IDLE, LAUNCH, WAIT_DONE and GAP, with registered state.
REQ-007 In IDLE with any i_req_valid high, the block SHALL select a winner by round-robin, searching from index (last_grant+1) mod NUM_REQ upward and wrapping.
REQ-008 On the same cycle as selection, the block SHALL drive o_req_ready[winner]=1 combinationally, capture the winner's byte into o_data_out, load o_grant_id, and go to LAUNCH on the next edge.
REQ-009 o_req_ready SHALL be high only in IDLE, for exactly one cycle per grant, and on at most one bit.
REQ-010 A requester SHALL be served only when its valid is high; valid dropping before the grant SHALL remove it from arbitration.
REQ-011 In LAUNCH, o_start_bit SHALL be 1, and o_data_out and o_grant_id SHALL remain stable.
REQ-012 The transition LAUNCH -> WAIT_DONE SHALL occur on the first cycle i_tx_busy=1 is sampled; o_start_bit SHALL be 0 from WAIT_DONE onward.
REQ-013 In WAIT_DONE, the block SHALL register i_tx_data_done and detect its rising edge; on that edge it SHALL update last_grant to o_grant_id and go to GAP.
REQ-014 GAP SHALL last GAP_CYC cycles, counted by a 4-bit counter, then go to IDLE; with GAP_CYC=0, GAP SHALL be skipped and WAIT_DONE SHALL go directly to IDLE.
REQ-015 The timeout counter SHALL be 10 bits, cleared on entry to LAUNCH, and increment in LAUNCH and WAIT_DONE.
REQ-016 When the timeout counter reaches TIMEOUT_CYC-1 without a done edge, the block SHALL:
- drop o_start_bit;
- set o_timeout_err;
- update last_grant so the failing requester is not starved and not retried first;
- go to GAP.
REQ-017 A done edge and the timeout occurring on the same cycle SHALL be treated as a successful done, with no error set.
REQ-018 A done edge detected in IDLE or LAUNCH (a stale flag) SHALL be ignored.
REQ-019 o_timeout_err SHALL stay set until i_err_clr=1 is sampled; a new timeout and i_err_clr on the same cycle SHALL leave the flag set (set has priority).
REQ-020 o_active SHALL be 1 in LAUNCH and WAIT_DONE, and 0 in IDLE and GAP.
REQ-021 The block SHALL buffer no data beyond the single in-flight byte; requesters SHALL hold valid and data until ready.

Reset
REQ-022 While i_tx_rst=0, the block SHALL force:
- state=IDLE;
- o_start_bit=0, o_data_out=8'h00, o_req_ready=0;
- o_grant_id=0, o_active=0, o_timeout_err=0;
- last_grant=NUM_REQ-1 (so requester 0 wins first);
- all counters and the registered done flag to 0.
REQ-023 Reset asserted mid-frame SHALL abort at once, with no ready pulse and no error flag; after release, the block SHALL behave as from power-up.
REQ-024 Reset release SHALL take effect on the first i_tx_clk edge after deassertion.

Verification
REQ-025 Single requester: req0 valid with 8'hA5, transmitter model busy 1 cycle after start and done 12 cycles later -> one ready[0] pulse, o_data_out=8'hA5, start high until busy, o_active high throughout, idle after 1 gap cycle.
REQ-026 Round-robin: all four valid continuously, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0, with exactly one frame between successive ready pulses.
REQ-027 Timeout: the transmitter model never asserts done -> o_timeout_err=1 exactly TIMEOUT_CYC cycles after LAUNCH entry, next grant goes to the next index, and i_err_clr returns the flag to 0.
REQ-028 Same-cycle done and timeout: done edge forced at count TIMEOUT_CYC-1 -> o_timeout_err stays 0 and the frame counts as complete.
REQ-029 Reset mid-frame: i_tx_rst low during WAIT_DONE -> all outputs at reset values within the same cycle; after release with req2 valid, requester 2 is granted.
REQ-030 Stale done: done held high while IDLE, then req1 granted -> no premature GAP; the block waits for a fresh rising edge.
